// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: decoded instruction, EX/WB bypass inputs, and the
// registered control word and operands going to the execute stage.
interface operand_fetch_if #(
    parameter int DATA_BITS             = 32,
    parameter int reg_addr_width        = 5,
    parameter int PROGRAM_COUNTER_WIDTH = 32,
    parameter int IMM_BITS              = 15
);
    // decoded instruction
    logic [reg_addr_width-1:0]        DA_in;
    logic [reg_addr_width-1:0]        AA;
    logic [reg_addr_width-1:0]        BA;
    logic                             MA;
    logic                             MB;
    logic                             CS;
    logic [IMM_BITS-1:0]              IM;
    logic                             RW_in;
    logic [1:0]                       MD_in;
    logic [1:0]                       BS_in;
    logic                             PS_in;
    logic                             MW_in;
    logic [3:0]                       FS_in;
    logic [4:0]                       SH_in;
    logic [PROGRAM_COUNTER_WIDTH-1:0] pc_in;

    // execute / writeback feedback
    logic                             RW_EX;
    logic [reg_addr_width-1:0]        DA_EX;
    logic [1:0]                       MD_EX;
    logic [DATA_BITS-1:0]             forward_data;
    logic                             RW_WB;
    logic [reg_addr_width-1:0]        DA_WB;
    logic [DATA_BITS-1:0]             wb_data;
    logic                             branch_taken;

    // registered outputs to execute
    logic                             RW;
    logic [reg_addr_width-1:0]        DA;
    logic [1:0]                       MD;
    logic [1:0]                       BS;
    logic                             PS;
    logic                             MW;
    logic [3:0]                       FS;
    logic [4:0]                       SH;
    logic [DATA_BITS-1:0]             BUSA;
    logic [DATA_BITS-1:0]             BUSB;
    logic [PROGRAM_COUNTER_WIDTH-1:0] pc_min_two;
    logic [DATA_BITS-1:0]             DData;
    logic                             stall;

    modport master (
        output DA_in, AA, BA, MA, MB, CS, IM,
        output RW_in, MD_in, BS_in, PS_in, MW_in, FS_in, SH_in, pc_in,
        output RW_EX, DA_EX, MD_EX, forward_data,
        output RW_WB, DA_WB, wb_data, branch_taken,
        input  RW, DA, MD, BS, PS, MW, FS, SH,
        input  BUSA, BUSB, pc_min_two, DData, stall
    );

    modport slave (
        input  DA_in, AA, BA, MA, MB, CS, IM,
        input  RW_in, MD_in, BS_in, PS_in, MW_in, FS_in, SH_in, pc_in,
        input  RW_EX, DA_EX, MD_EX, forward_data,
        input  RW_WB, DA_WB, wb_data, branch_taken,
        output RW, DA, MD, BS, PS, MW, FS, SH,
        output BUSA, BUSB, pc_min_two, DData, stall
    );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: register file, operand muxing, EX/WB bypass and
// the pipeline register into execute. LOAD_STALL_EN adds a one-cycle load-use stall.
module operand_fetch #(
    parameter int DATA_BITS             = 32,
    parameter int reg_addr_width        = 5,
    parameter int PROGRAM_COUNTER_WIDTH = 32,
    parameter int IMM_BITS              = 15
) (
    input logic              clk,
    input logic              rst,
    operand_fetch_if.slave   bus
);

    localparam int NUM_REGS = 2 ** reg_addr_width;

    logic [DATA_BITS-1:0] reg_file [NUM_REGS];

    logic                 ex_fwd_ok;
    logic                 stall_int;
    logic                 bubble;
    logic [DATA_BITS-1:0] raw_a;
    logic [DATA_BITS-1:0] raw_b;
    logic [DATA_BITS-1:0] imm_ext;
    logic [DATA_BITS-1:0] pc_ext;

    logic                             rw_next;
    logic [reg_addr_width-1:0]        da_next;
    logic [1:0]                       md_next;
    logic [1:0]                       bs_next;
    logic                             ps_next;
    logic                             mw_next;
    logic [3:0]                       fs_next;
    logic [4:0]                       sh_next;
    logic [DATA_BITS-1:0]             busa_next;
    logic [DATA_BITS-1:0]             busb_next;
    logic [PROGRAM_COUNTER_WIDTH-1:0] pcm_next;
    logic [DATA_BITS-1:0]             ddata_next;

    function automatic logic [DATA_BITS-1:0] raw_read(
        input logic [reg_addr_width-1:0] sel,
        input logic                      fwd_ok,
        input logic [reg_addr_width-1:0] da_ex,
        input logic [DATA_BITS-1:0]      fwd,
        input logic                      rw_wb,
        input logic [reg_addr_width-1:0] da_wb,
        input logic [DATA_BITS-1:0]      wb,
        input logic [DATA_BITS-1:0]      rf_val
    );
        if (sel == '0)
            return '0;
        else if (fwd_ok && da_ex == sel)
            return fwd;
        else if (rw_wb && da_wb == sel)
            return wb;
        else
            return rf_val;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                reg_file[i] <= '0;
        end else if (bus.RW_WB && bus.DA_WB != '0) begin
            reg_file[bus.DA_WB] <= bus.wb_data;
        end
    end

`ifdef LOAD_STALL_EN
    // A load in EX has no data yet; its result is picked up from WB after the stall.
    assign ex_fwd_ok = bus.RW_EX && (bus.MD_EX != 2'b01);

    always_comb begin
        stall_int = 1'b0;
        if (!rst && !bus.branch_taken && bus.RW_EX && bus.MD_EX == 2'b01 &&
            bus.DA_EX != '0) begin
            stall_int = (!bus.MA && bus.AA == bus.DA_EX) ||
                        (!bus.MB && bus.BA == bus.DA_EX) ||
                        (bus.BA == bus.DA_EX);
        end
    end
`else
    logic unused_md_ex;
    assign unused_md_ex = ^bus.MD_EX;
    assign ex_fwd_ok    = bus.RW_EX;
    assign stall_int    = 1'b0;
`endif

    assign bus.stall = stall_int;
    assign bubble    = bus.branch_taken || stall_int;

    assign raw_a = raw_read(bus.AA, ex_fwd_ok, bus.DA_EX, bus.forward_data,
                            bus.RW_WB, bus.DA_WB, bus.wb_data, reg_file[bus.AA]);
    assign raw_b = raw_read(bus.BA, ex_fwd_ok, bus.DA_EX, bus.forward_data,
                            bus.RW_WB, bus.DA_WB, bus.wb_data, reg_file[bus.BA]);

    assign imm_ext = bus.CS ? DATA_BITS'($signed(bus.IM)) : DATA_BITS'(bus.IM);
    assign pc_ext  = DATA_BITS'(bus.pc_in);

    // Bubble values are all-zero, so the default doubles as the squash path.
    always_comb begin
        rw_next    = 1'b0;
        da_next    = '0;
        md_next    = 2'b00;
        bs_next    = 2'b00;
        ps_next    = 1'b0;
        mw_next    = 1'b0;
        fs_next    = '0;
        sh_next    = '0;
        busa_next  = '0;
        busb_next  = '0;
        pcm_next   = '0;
        ddata_next = '0;
        if (!bubble) begin
            rw_next    = bus.RW_in;
            da_next    = bus.DA_in;
            md_next    = bus.MD_in;
            bs_next    = bus.BS_in;
            ps_next    = bus.PS_in;
            mw_next    = bus.MW_in;
            fs_next    = bus.FS_in;
            sh_next    = bus.SH_in;
            busa_next  = bus.MA ? pc_ext : raw_a;
            busb_next  = bus.MB ? imm_ext : raw_b;
            pcm_next   = bus.pc_in;
            ddata_next = raw_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.RW         <= 1'b0;
            bus.DA         <= '0;
            bus.MD         <= 2'b00;
            bus.BS         <= 2'b00;
            bus.PS         <= 1'b0;
            bus.MW         <= 1'b0;
            bus.FS         <= '0;
            bus.SH         <= '0;
            bus.BUSA       <= '0;
            bus.BUSB       <= '0;
            bus.pc_min_two <= '0;
            bus.DData      <= '0;
        end else begin
            bus.RW         <= rw_next;
            bus.DA         <= da_next;
            bus.MD         <= md_next;
            bus.BS         <= bs_next;
            bus.PS         <= ps_next;
            bus.MW         <= mw_next;
            bus.FS         <= fs_next;
            bus.SH         <= sh_next;
            bus.BUSA       <= busa_next;
            bus.BUSB       <= busb_next;
            bus.pc_min_two <= pcm_next;
            bus.DData      <= ddata_next;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: the driver queues hand-computed expected
// outputs per issued vector, a monitor pops and compares each registered result.
module tb_operand_fetch;

    typedef struct packed {
        logic [4:0]  da, aa, ba;
        logic        ma, mb, cs;
        logic [14:0] im;
        logic        rw;
        logic [1:0]  md, bs;
        logic        ps, mw;
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic [31:0] pc;
        logic        rw_ex;
        logic [4:0]  da_ex;
        logic [1:0]  md_ex;
        logic [31:0] fwd;
        logic        rw_wb;
        logic [4:0]  da_wb;
        logic [31:0] wb;
        logic        br;
    } in_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md, bs;
        logic        ps, mw;
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic [31:0] busa, busb, pcm, ddata;
        logic        stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_t  exp_q[$];
    string name_q[$];

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t nop();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic exp_t bub_e(input logic stall);
        exp_t e;
        e = '0;
        e.stall = stall;
        return e;
    endfunction

    function automatic exp_t pass_e(input in_t v, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] d);
        exp_t e;
        e.rw = v.rw; e.da = v.da; e.md = v.md; e.bs = v.bs;
        e.ps = v.ps; e.mw = v.mw; e.fs = v.fs; e.sh = v.sh;
        e.busa = a; e.busb = b; e.pcm = v.pc; e.ddata = d;
        e.stall = 1'b0;
        return e;
    endfunction

    function exp_t sample();
        exp_t e;
        e.rw = bus.RW; e.da = bus.DA; e.md = bus.MD; e.bs = bus.BS;
        e.ps = bus.PS; e.mw = bus.MW; e.fs = bus.FS; e.sh = bus.SH;
        e.busa = bus.BUSA; e.busb = bus.BUSB; e.pcm = bus.pc_min_two;
        e.ddata = bus.DData; e.stall = bus.stall;
        return e;
    endfunction

    task automatic apply(input in_t v);
        bus.DA_in = v.da; bus.AA = v.aa; bus.BA = v.ba;
        bus.MA = v.ma; bus.MB = v.mb; bus.CS = v.cs; bus.IM = v.im;
        bus.RW_in = v.rw; bus.MD_in = v.md; bus.BS_in = v.bs;
        bus.PS_in = v.ps; bus.MW_in = v.mw; bus.FS_in = v.fs; bus.SH_in = v.sh;
        bus.pc_in = v.pc;
        bus.RW_EX = v.rw_ex; bus.DA_EX = v.da_ex; bus.MD_EX = v.md_ex;
        bus.forward_data = v.fwd;
        bus.RW_WB = v.rw_wb; bus.DA_WB = v.da_wb; bus.wb_data = v.wb;
        bus.branch_taken = v.br;
    endtask

    task automatic chk(input string name, input exp_t got, input exp_t e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got rw=%b da=%0d md=%b bs=%b ps=%b mw=%b fs=%h sh=%0d A=%h B=%h pc=%h D=%h stall=%b | exp rw=%b da=%0d md=%b bs=%b ps=%b mw=%b fs=%h sh=%0d A=%h B=%h pc=%h D=%h stall=%b",
                     name, got.rw, got.da, got.md, got.bs, got.ps, got.mw, got.fs, got.sh,
                     got.busa, got.busb, got.pcm, got.ddata, got.stall,
                     e.rw, e.da, e.md, e.bs, e.ps, e.mw, e.fs, e.sh,
                     e.busa, e.busb, e.pcm, e.ddata, e.stall);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int e);
        checks++;
        if (got != e) begin
            failures++;
            $display("FAIL %s: got %0d exp %0d", name, got, e);
        end
    endtask

    task automatic drive(input in_t v, input exp_t e, input string name);
        @(negedge clk);
        apply(v);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: stall is sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        logic  st;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0 && !rst) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                st = bus.stall;
                @(posedge clk);
                #1;
                got = sample();
                got.stall = st;
                chk(nm, got, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t v;

        v = nop();
        v.rw = 1'b1; v.mw = 1'b1; v.aa = 5'd3; v.pc = 32'h10; v.ma = 1'b1;
        apply(v);
        repeat (2) @(posedge clk);
        #1;
        chk("reset", sample(), bub_e(1'b0));
        @(negedge clk);
        apply(nop());
        rst = 1'b0;

        v = nop(); v.rw = 1'b1; v.da = 5'd1; v.fs = 4'h2; v.pc = 32'h100;
        v.rw_wb = 1'b1; v.da_wb = 5'd5; v.wb = 32'h0000_1234;
        drive(v, pass_e(v, 32'h0, 32'h0, 32'h0), "wb_r5");

        v = nop(); v.aa = 5'd5; v.pc = 32'h104; v.sh = 5'd3; v.md = 2'b10;
        drive(v, pass_e(v, 32'h0000_1234, 32'h0, 32'h0), "read_r5");

        v = nop(); v.aa = 5'd5; v.ba = 5'd3; v.pc = 32'h108; v.da = 5'd9;
        v.rw_wb = 1'b1; v.da_wb = 5'd3; v.wb = 32'hDEAD_BEEF;
        drive(v, pass_e(v, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF), "wt_r3");

        v = nop(); v.ba = 5'd3; v.ps = 1'b1;
        drive(v, pass_e(v, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF), "read_r3");

        v = nop(); v.aa = 5'd7; v.ba = 5'd7;
        v.rw_ex = 1'b1; v.da_ex = 5'd7; v.fwd = 32'h55;
        v.rw_wb = 1'b1; v.da_wb = 5'd7; v.wb = 32'h99;
        drive(v, pass_e(v, 32'h55, 32'h55, 32'h55), "ex_prio");

        v = nop(); v.aa = 5'd0; v.ba = 5'd7;
        v.rw_ex = 1'b1; v.da_ex = 5'd0; v.fwd = 32'h55;
        v.rw_wb = 1'b1; v.da_wb = 5'd0; v.wb = 32'hAA;
        drive(v, pass_e(v, 32'h0, 32'h99, 32'h99), "r0_zero");

        v = nop(); v.ma = 1'b1; v.pc = 32'h40; v.mb = 1'b1; v.im = 15'h4000;
        v.cs = 1'b1; v.ba = 5'd3;
        drive(v, pass_e(v, 32'h40, 32'hFFFF_C000, 32'hDEAD_BEEF), "imm_sext");

        v = nop(); v.aa = 5'd5; v.mb = 1'b1; v.im = 15'h4000; v.cs = 1'b0; v.ba = 5'd3;
        drive(v, pass_e(v, 32'h0000_1234, 32'h0000_4000, 32'hDEAD_BEEF), "imm_zext");

        v = nop(); v.br = 1'b1; v.rw = 1'b1; v.mw = 1'b1; v.bs = 2'b10; v.ps = 1'b1;
        v.aa = 5'd5; v.ba = 5'd3; v.pc = 32'h200; v.da = 5'd6;
        drive(v, bub_e(1'b0), "branch_squash");

        v = nop(); v.rw = 1'b1; v.mw = 1'b1; v.bs = 2'b01; v.aa = 5'd5;
        v.pc = 32'h204; v.da = 5'd6;
        drive(v, pass_e(v, 32'h0000_1234, 32'h0, 32'h0), "post_branch");

        v = nop(); v.aa = 5'd4; v.rw_ex = 1'b1; v.md_ex = 2'b01; v.da_ex = 5'd4;
        v.fwd = 32'h66; v.pc = 32'h208; v.rw = 1'b1; v.da = 5'd2; v.md = 2'b01;
`ifdef LOAD_STALL_EN
        drive(v, bub_e(1'b1), "load_use");
`else
        drive(v, pass_e(v, 32'h66, 32'h0, 32'h0), "load_use");
`endif

        v = nop(); v.aa = 5'd4; v.rw_wb = 1'b1; v.da_wb = 5'd4; v.wb = 32'h77;
        v.pc = 32'h208; v.rw = 1'b1; v.da = 5'd2; v.md = 2'b01;
        drive(v, pass_e(v, 32'h77, 32'h0, 32'h0), "load_wb");

        v = nop(); v.aa = 5'd4; v.rw_ex = 1'b1; v.md_ex = 2'b01; v.da_ex = 5'd4;
        v.fwd = 32'h66; v.br = 1'b1; v.rw = 1'b1;
        drive(v, bub_e(1'b0), "load_branch");

        v = nop(); v.mb = 1'b1; v.im = 15'h0010; v.ba = 5'd4;
        v.rw_ex = 1'b1; v.md_ex = 2'b01; v.da_ex = 5'd4; v.fwd = 32'h66;
`ifdef LOAD_STALL_EN
        drive(v, bub_e(1'b1), "load_ddata");
`else
        drive(v, pass_e(v, 32'h0, 32'h10, 32'h66), "load_ddata");
`endif

        v = nop(); v.ma = 1'b1; v.pc = 32'h300; v.aa = 5'd4; v.mb = 1'b1;
        v.im = 15'h7FFF; v.cs = 1'b1; v.ba = 5'd0;
        v.rw_ex = 1'b1; v.md_ex = 2'b01; v.da_ex = 5'd4; v.fwd = 32'h66;
        drive(v, pass_e(v, 32'h300, 32'hFFFF_FFFF, 32'h0), "load_no_dep");

        v = nop(); v.aa = 5'd4; v.ba = 5'd5;
        drive(v, pass_e(v, 32'h77, 32'h0000_1234, 32'h0000_1234), "rf_r4_r5");

        @(negedge clk);
        apply(nop());
        @(posedge clk);
        #3;
        chk_int("queue_drained", exp_q.size(), 0);

        // Async reset while a dependent load is holding the stage.
        @(negedge clk);
        v = nop(); v.aa = 5'd5; v.rw = 1'b1; v.pc = 32'h400;
        apply(v);
        @(posedge clk);
        #1;
        chk("pre_reset", sample(), pass_e(v, 32'h0000_1234, 32'h0, 32'h0));
        v = nop(); v.aa = 5'd4; v.rw_ex = 1'b1; v.md_ex = 2'b01; v.da_ex = 5'd4;
        apply(v);
        #1;
`ifdef LOAD_STALL_EN
        chk_int("stall_before_reset", int'(bus.stall), 1);
`else
        chk_int("stall_before_reset", int'(bus.stall), 0);
`endif
        rst = 1'b1;
        #1;
        chk("async_reset", sample(), bub_e(1'b0));
        @(posedge clk);
        #1;
        chk("reset_hold", sample(), bub_e(1'b0));
        @(negedge clk);
        apply(nop());
        rst = 1'b0;

        v = nop(); v.aa = 5'd5; v.ba = 5'd7; v.pc = 32'h500;
        drive(v, pass_e(v, 32'h0, 32'h0, 32'h0), "rf_cleared");

        @(negedge clk);
        apply(nop());
        @(posedge clk);
        #3;
        chk_int("queue_drained_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch pipeline stage directly upstream of the execute stage.
- Holds the 32-entry register file, written by the writeback stage.
- Resolves the A/B operands: register data, PC, or a sign-/zero-extended immediate.
- Forwards results from the execute and writeback stages, squashes the instruction on a taken branch, and registers the full control word plus BUSA/BUSB into the execute stage.

Parameters:
DATA_BITS, 32, datapath width
reg_addr_width, 5, register address width (2**reg_addr_width registers)
PROGRAM_COUNTER_WIDTH, 32, PC width
IMM_BITS, 15, immediate field width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
DA_in  input  5  destination register
AA  input  5  source A register
BA  input  5  source B register
MA  input  1  1: BUSA = pc_in, 0: register A
MB  input  1  1: BUSB = extended immediate, 0: register B
CS  input  1  1: sign-extend IM, 0: zero-extend
IM  input  IMM_BITS  immediate
RW_in, MD_in[1:0], BS_in[1:0], PS_in, MW_in, FS_in[3:0], SH_in[4:0]  input  -  decoded control word
pc_in  input  PROGRAM_COUNTER_WIDTH  PC of this instruction
RW_EX  input  1  execute-stage register-write flag
DA_EX  input  5  execute-stage destination
MD_EX  input  2  execute-stage result select
forward_data  input  DATA_BITS  execute-stage result
RW_WB  input  1  writeback write enable
DA_WB  input  5  writeback destination
wb_data  input  DATA_BITS  writeback data
branch_taken  input  1  branch resolved taken in execute
RW, DA, MD, BS, PS, MW, FS, SH  output  -  registered control word to execute
BUSA, BUSB  output  DATA_BITS  registered operands
pc_min_two  output  PROGRAM_COUNTER_WIDTH  registered pc_in
DData  output  DATA_BITS  registered register-B value, used as store data
stall  output  1  hold fetch (PC and IR); combinational

Behaviour:
Register file:
- 32 x DATA_BITS.
- R0 always reads 0; writes to R0 are ignored.
- Written on posedge clk when RW_WB=1.
- Reset clears all entries.

Raw read for source X (AA or BA), priority order:
- X==0 → 0.
- RW_EX && DA_EX==X → forward_data.
- RW_WB && DA_WB==X → wb_data (same-cycle write-through).
- Otherwise → register file.

Operand selection:
- BUSA_next = MA ? pc_in zero-extended/truncated to DATA_BITS : rawA.
- BUSB_next = MB ? {sign- or zero-extended IM} : rawB.
- DData_next = rawB, always, regardless of MB.

Pipeline register:
- All outputs register on every posedge clk unless a bubble is inserted.
- Latency from inputs to outputs is 1 cycle.

Bubble (inserted when branch_taken=1, or stall=1):
- RW=0, MW=0, BS=00, PS=0.
- DA=0, MD=00, FS=0, SH=0.
- BUSA=BUSB=DData=0, pc_min_two=0.

branch_taken:
- Squashes the instruction currently in this stage.
- Takes priority over stall.
- stall is forced to 0 that cycle.

Reset:
- All outputs go to bubble values asynchronously.
- stall=0; register file is cleared.
- Reset mid-stall clears the stall; no state survives.

Optional Feature:
- Macro LOAD_STALL_EN.
- Defined:
  - stall=1 when MD_EX==01 && RW_EX && DA_EX!=0 && ((MA==0 && AA==DA_EX) || (MB==0 && BA==DA_EX) || BA==DA_EX for DData), and branch_taken=0.
  - This stage issues one bubble and the same instruction is re-presented next cycle. At that point the load is in writeback and the value is taken from wb_data.
  - The stall lasts exactly one cycle per dependent load.
  - Forwarding from EX applies only when MD_EX!=01.
- Not defined:
  - stall is tied 0.
  - EX forwarding applies for all MD_EX values; forward_data already carries memory data.

Test Plan:
- Reset, then write R5=0x0000_1234 via WB, next cycle AA=5, MA=0 → BUSA=0x0000_1234 one cycle later.
- RW_WB=1, DA_WB=3, wb_data=0xDEAD_BEEF in the same cycle as BA=3 → BUSB=DData=0xDEAD_BEEF (write-through).
- RW_EX=1, DA_EX=7, forward_data=0x55, while WB also writes R7=0x99; AA=7 → BUSA=0x55 (EX priority). Same with AA=0 → BUSA=0.
- MB=1, IM=0x4000, CS=1 → BUSB=0xFFFF_C000; CS=0 → 0x0000_4000. MA=1, pc_in=0x40 → BUSA=0x40.
- branch_taken=1 with RW_in=1, MW_in=1 → next cycle RW=0, MW=0, BS=00, all data outputs 0; the following instruction passes normally.
- LOAD_STALL_EN: MD_EX=01, RW_EX=1, DA_EX=4, AA=4 → stall=1 for one cycle with a bubble emitted. Next cycle, with wb_data=0x77 and DA_WB=4 → BUSA=0x77, stall=0. Repeat with branch_taken=1 → stall=0.
